// File: rtl/imem_load_arbiter.sv
// Writable instruction store shared by the CPU fetch port and an image loader.
// Clears to NOP after reset, accepts a program image, then arbitrates fetch against hot-patch writes.
module imem_load_arbiter #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = 4,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_ack,
  output logic [31:0]   fetch_inst,
  output logic          cpu_stall,
  output logic [1:0]    state_o,
  output logic [AW:0]   ld_count
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'b00,
    ST_LOAD  = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_clr_idx;
  logic [AW:0]   r_ld_count;
  logic          r_fair;
  logic [31:0]   r_mem [DEPTH];
  logic          r_fetch_ack;
  logic [31:0]   r_fetch_inst;

  logic          w_ld_grant;
  logic          w_fetch_grant;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [31:0]   w_wdata;
  logic          w_fair_nxt;
  logic          w_fetch_oor;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_CLEAR;
    else        r_state <= w_state_nxt;
  end

  // Next state, grants and write port selection
  always_comb begin
    w_state_nxt   = r_state;
    w_ld_grant    = 1'b0;
    w_fetch_grant = 1'b0;
    w_we          = 1'b0;
    w_waddr       = ld_addr;
    w_wdata       = ld_data;
    w_fair_nxt    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_clr_idx;
        w_wdata = NOP_WORD;
        if (r_clr_idx == AW'(DEPTH - 1)) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_ld_grant = 1'b1;
        w_we       = ld_valid;
        if (ld_valid && ld_last) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // Loader wins a conflict unless it won the previous one
        w_ld_grant    = ld_valid & (~fetch_req | ~r_fair);
        w_fetch_grant = fetch_req & (~ld_valid | r_fair);
        w_we          = w_ld_grant;
        w_fair_nxt    = fetch_req & ld_valid & ~r_fair;
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  // Clear index, load counter and fairness flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_idx  <= '0;
      r_ld_count <= '0;
      r_fair     <= 1'b0;
    end else begin
      r_fair <= w_fair_nxt;
      if (r_state == ST_CLEAR) begin
        r_clr_idx  <= r_clr_idx + AW'(1);
        r_ld_count <= '0;
      end else if (r_state == ST_LOAD && w_we && r_ld_count != CW'(DEPTH)) begin
        r_ld_count <= r_ld_count + CW'(1);
      end
    end
  end

  // Storage array; contents undefined until the clear pass completes
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign w_fetch_oor = |fetch_addr[31:AW];

  // Registered fetch read; never coincides with a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_ack  <= 1'b0;
      r_fetch_inst <= NOP_WORD;
    end else begin
      r_fetch_ack <= w_fetch_grant;
      if (w_fetch_grant) begin
        r_fetch_inst <= w_fetch_oor ? NOP_WORD : r_mem[fetch_addr[AW-1:0]];
      end
    end
  end

  assign ld_ready   = w_ld_grant;
  assign fetch_ack  = r_fetch_ack;
  assign fetch_inst = r_fetch_inst;
  assign cpu_stall  = (r_state != ST_RUN) | (fetch_req & ~w_fetch_grant);
  assign state_o    = r_state;
  assign ld_count   = r_ld_count;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter: clear, image load, fetch, arbitration, hot patch, reset abort.
module tb_imem_load_arbiter;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_ack;
  logic [31:0]   fetch_inst;
  logic          cpu_stall;
  logic [1:0]    state_o;
  logic [AW:0]   ld_count;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] PROG [13] = '{
    32'h20010001, 32'h20020002, 32'h00221820, 32'h00622022,
    32'h20050007, 32'h00a43020, 32'h00c53822, 32'h20080010,
    32'h01074020, 32'h2009ffff, 32'h01294820, 32'h00000020,
    32'h1000ffff
  };

  imem_load_arbiter #(.DEPTH(16), .AW(AW), .NOP_WORD(32'h00000000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ack  (fetch_ack),
    .fetch_inst (fetch_inst),
    .cpu_stall  (cpu_stall),
    .state_o    (state_o),
    .ld_count   (ld_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    #1;
    chk({tag, "_stall"}, 32'(cpu_stall), 32'd0);
    tick();
    chk({tag, "_ack"}, 32'(fetch_ack), 32'd1);
    chk({tag, "_inst"}, fetch_inst, exp);
    fetch_req = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    ld_valid   = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    ld_last    = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'd0;

    // Reset values
    tick();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_ack", 32'(fetch_ack), 32'd0);
    chk("rst_inst", fetch_inst, 32'd0);
    chk("rst_cnt", 32'(ld_count), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd1);
    tick();
    rst_n = 1'b1;

    // Sixteen CLEAR cycles with fetch requested throughout
    for (int c = 1; c <= 16; c++) begin
      #1;
      chk("clr_state", 32'(state_o), 32'd0);
      chk("clr_stall", 32'(cpu_stall), 32'd1);
      chk("clr_ack", 32'(fetch_ack), 32'd0);
      chk("clr_ready", 32'(ld_ready), 32'd0);
      tick();
    end
    chk("load_state", 32'(state_o), 32'd1);
    chk("load_ready", 32'(ld_ready), 32'd1);
    chk("load_stall", 32'(cpu_stall), 32'd1);

    // Program image load
    fetch_req = 1'b0;
    for (int i = 0; i < 13; i++) begin
      ld_valid = 1'b1;
      ld_addr  = AW'(i);
      ld_data  = PROG[i];
      ld_last  = (i == 12);
      #1;
      chk("ld_state", 32'(state_o), 32'd1);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    #1;
    chk("run_state", 32'(state_o), 32'd2);
    chk("run_cnt", 32'(ld_count), 32'd13);
    chk("run_stall", 32'(cpu_stall), 32'd0);

    // Back-to-back fetch of whole store
    for (int i = 0; i < 16; i++) begin
      fetch_chk("fetch", 32'(i), (i < 13) ? PROG[i] : 32'h0);
      fetch_req = 1'b1;
    end
    fetch_req = 1'b0;
    #1;
    tick();
    chk("idle_ack", 32'(fetch_ack), 32'd0);

    // Conflict: grants alternate L,F,L,F
    for (int k = 1; k <= 4; k++) begin
      fetch_req  = 1'b1;
      fetch_addr = 32'd5;
      ld_valid   = 1'b1;
      ld_addr    = AW'(14);
      ld_data    = 32'hA0 + 32'(k);
      #1;
      chk("cf_ready", 32'(ld_ready), 32'(k % 2));
      chk("cf_stall", 32'(cpu_stall), 32'(k % 2));
      tick();
      chk("cf_ack", 32'(fetch_ack), 32'((k + 1) % 2));
      if (k % 2 == 0) chk("cf_inst", fetch_inst, PROG[5]);
    end
    ld_valid = 1'b0;
    fetch_chk("cf_wr14", 32'd14, 32'h000000A3);
    chk("cf_cnt_hold", 32'(ld_count), 32'd13);

    // Hot patch then immediate fetch of same index
    ld_valid = 1'b1;
    ld_addr  = AW'(2);
    ld_data  = 32'h20010005;
    #1;
    chk("hp_ready", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    fetch_chk("hp", 32'd2, 32'h20010005);

    // Out-of-range fetch addresses
    fetch_chk("oor20", 32'd20, 32'h0);
    fetch_chk("in3", 32'd3, PROG[3]);
    fetch_chk("oor_hi", 32'h80000003, 32'h0);

    // Reset during LOAD after five writes
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (16) tick();
    chk("r2_load", 32'(state_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1;
      ld_addr  = AW'(i);
      ld_data  = 32'hDEAD0000 + 32'(i);
      tick();
    end
    chk("r2_cnt5", 32'(ld_count), 32'd5);
    ld_addr = AW'(5);
    rst_n   = 1'b0;
    #1;
    chk("abort_state", 32'(state_o), 32'd0);
    chk("abort_cnt", 32'(ld_count), 32'd0);
    chk("abort_ready", 32'(ld_ready), 32'd0);
    chk("abort_stall", 32'(cpu_stall), 32'd1);
    tick();
    ld_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (16) tick();
    chk("r3_load", 32'(state_o), 32'd1);
    ld_valid = 1'b1;
    ld_addr  = AW'(10);
    ld_data  = 32'h00001234;
    ld_last  = 1'b1;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("r3_run", 32'(state_o), 32'd2);
    chk("r3_cnt", 32'(ld_count), 32'd1);
    fetch_chk("r3_old3", 32'd3, 32'h0);
    fetch_chk("r3_new10", 32'd10, 32'h00001234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
- Writable instruction store of DEPTH x 32-bit words, shared between two requesters: the CPU fetch port (read) and a loader port (write, valid/ready).
- On reset it clears the store to NOP, accepts a program image from the loader, then releases the CPU.
- In RUN it arbitrates between fetch and loader hot-patch writes. Loader wins a conflict, but never twice in a row while fetch is waiting.
- Replaces the hard-wired instruction ROM in the single-cycle CPU.

Parameters:
DEPTH, 16, number of 32-bit instruction words
AW, 4, word-index width; log2(DEPTH)
NOP_WORD, 32'h00000000, value used for clearing and for out-of-range fetches

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ld_valid  in  1  loader write request
ld_ready  out  1  store accepts loader write this cycle
ld_addr  in  AW  loader word index
ld_data  in  32  loader write data
ld_last  in  1  qualifies the final write of the image; valid only with ld_valid
fetch_req  in  1  CPU requests instruction
fetch_addr  in  32  word index (not byte address) from PC
fetch_ack  out  1  fetch_inst valid this cycle
fetch_inst  out  32  fetched instruction
cpu_stall  out  1  CPU must hold PC this cycle
state_o  out  2  00 CLEAR, 01 LOAD, 10 RUN
ld_count  out  AW+1  writes accepted since entering LOAD, saturating at DEPTH

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=CLEAR; clear index=0; ld_ready=0; fetch_ack=0; fetch_inst=NOP_WORD; ld_count=0; cpu_stall=1; fairness flag=0.
  - Reset asserted mid-operation aborts everything and restarts at CLEAR. Memory contents are not guaranteed until CLEAR completes.
- CLEAR:
  - One word per cycle: mem[idx]<=NOP_WORD, idx 0..DEPTH-1.
  - After the write of idx=DEPTH-1, state goes to LOAD (exactly DEPTH cycles).
  - ld_ready=0 and fetch requests are ignored.
- LOAD:
  - ld_ready=1. A write occurs on ld_valid&ld_ready; ld_count increments, saturating at DEPTH.
  - ld_valid&ld_ready&ld_last: the data is written and the state becomes RUN on the next cycle.
  - fetch_req is ignored; fetch_ack=0.
- RUN, arbitration per cycle:
  - Only fetch_req: grant fetch.
  - Only ld_valid: grant loader.
  - Both requesting:
    - fairness flag=0: grant loader, then set flag=1.
    - fairness flag=1: grant fetch, then clear flag.
  - The flag clears on any cycle without a conflict.
  - ld_ready = loader granted (combinational from the request inputs); ld_last is ignored in RUN.
  - ld_count holds in RUN.
- Fetch timing:
  - A granted fetch at cycle N gives fetch_ack=1 and fetch_inst=mem[fetch_addr[AW-1:0]] at cycle N+1 (registered read, 1-cycle latency).
  - fetch_addr>=DEPTH (any upper bit set) returns NOP_WORD with ack.
  - fetch_ack=0 in any cycle following a non-granted or absent fetch. fetch_inst holds its last value when ack=0.
- Read/write hazards:
  - Fetch and write never occur in the same cycle.
  - A write to address A at cycle N followed by a fetch of A at N+1 returns the new data.
- cpu_stall (combinational) = (state!=RUN) | (fetch_req & ~fetch_granted).
- ld_addr out of range cannot occur (AW bits). DEPTH must be 2^AW.
- state_o reflects the registered state.

Test Plan:
- Reset release: fetch_req=1 throughout -> state_o=CLEAR for 16 cycles, then LOAD. cpu_stall=1, fetch_ack=0 throughout, ld_ready first high on cycle 17.
- Load 13 words (addi/add/sub/... image), last with ld_last -> ld_count=13, RUN one cycle after final handshake. Fetching indices 0..15 returns the image for 0..12, then 32'h0 for 13..15, each one cycle after request.
- RUN: fetch_req and ld_valid both high for 4 cycles -> grants alternate L,F,L,F. cpu_stall=1 on cycles 1 and 3. fetch_ack high on cycles 3 and 5. Loader writes accepted on cycles 1 and 3.
- Hot patch: write 32'h20010005 to index 2 at cycle N, fetch index 2 at N+1 -> fetch_inst=32'h20010005 at N+2.
- fetch_addr=32'd20 in RUN -> fetch_ack=1, fetch_inst=32'h00000000.
- Assert rst_n low mid-LOAD after 5 writes -> immediate CLEAR, ld_count=0, ld_ready=0. After re-clear, fetch of previously written index returns 32'h0.
